// File: rtl/mips_defs_pkg.sv
// Definitions shared by the fetch stage and the controller decoder:
// NOP encoding, opcode/funct constants, fetch FSM encoding and jump-target helper.
package mips_defs;

  // sll $0,$0,0
  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_ADD   = 6'h20;
  localparam logic [5:0] FN_SUB   = 6'h22;
  localparam logic [5:0] FN_AND   = 6'h24;
  localparam logic [5:0] FN_OR    = 6'h25;
  localparam logic [5:0] FN_SLT   = 6'h2A;

  typedef logic [1:0] fetch_state_t;

  localparam fetch_state_t FS_IDLE  = 2'd0;
  localparam fetch_state_t FS_FETCH = 2'd1;
  localparam fetch_state_t FS_HOLD  = 2'd2;

  function automatic logic [31:0] jump_target(input logic [31:0] pcplus4,
                                              input logic [31:0] instr);
    return {pcplus4[31:28], instr[25:0], 2'b00};
  endfunction

endpackage

// File: rtl/ifid_reg.sv
// IF/ID pipeline register: instruction, pc+4 and valid bit.
// Clear beats load so a squash always leaves a bubble.
module ifid_reg
  import mips_defs::*;
#(
  parameter logic [31:0] NOP_WORD = NOP_INSTR
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load_i,
  input  logic        clear_i,
  input  logic [31:0] instr_i,
  input  logic [31:0] pcplus4_i,
  output logic [31:0] instr_o,
  output logic [31:0] pcplus4_o,
  output logic        valid_o
);

  logic [31:0] instr_q;
  logic [31:0] pcplus4_q;
  logic        valid_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      instr_q   <= NOP_WORD;
      pcplus4_q <= '0;
      valid_q   <= 1'b0;
    end else if (clear_i) begin
      instr_q   <= NOP_WORD;
      pcplus4_q <= '0;
      valid_q   <= 1'b0;
    end else if (load_i) begin
      instr_q   <= instr_i;
      pcplus4_q <= pcplus4_i;
      valid_q   <= 1'b1;
    end
  end

  assign instr_o   = instr_q;
  assign pcplus4_o = pcplus4_q;
  assign valid_o   = valid_q;

endmodule

// File: rtl/instr_fetch.sv
// IF stage: owns the PC, fetches words over a req/ready handshake and fills IF/ID.
// Branch/jump redirects restart fetch; a word still in flight at redirect is dropped.
module instr_fetch
  import mips_defs::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_WORD = NOP_INSTR
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  input  logic        jump,
  input  logic        flush,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr_d,
  output logic [31:0] pcplus4_d,
  output logic        valid_d,
  output logic [5:0]  op_d,
  output logic [5:0]  funct_d
);

  fetch_state_t state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  hold_q, hold_d;
  logic         hold_valid_q, hold_valid_d;
  logic         drop_q, drop_d;

  logic [31:0]  pc_plus4;
  logic [31:0]  redirect_target;
  logic         redirect;
  logic         ifid_load;
  logic         ifid_clear;
  logic [31:0]  ifid_instr;

  assign pc_plus4        = pc_q + 32'd4;
  assign redirect        = branch_taken | jump;
  assign redirect_target = branch_taken ? branch_target : jump_target(pcplus4_d, instr_d);

  assign imem_req  = (state_q == FS_FETCH);
  assign imem_addr = pc_q;

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    hold_d       = hold_q;
    hold_valid_d = hold_valid_q;
    drop_d       = drop_q;
    ifid_load    = 1'b0;
    ifid_clear   = flush | redirect;
    ifid_instr   = imem_rdata;

    if (redirect) begin
      pc_d         = redirect_target;
      hold_valid_d = 1'b0;
      state_d      = FS_FETCH;
      // An unanswered request will still return a word for the old pc.
      drop_d       = imem_req & ~imem_ready;
    end else begin
      case (state_q)
        FS_IDLE: state_d = FS_FETCH;
        FS_FETCH: begin
          if (imem_ready) begin
            if (drop_q) begin
              drop_d = 1'b0;
            end else if (stall) begin
              hold_d       = imem_rdata;
              hold_valid_d = 1'b1;
              state_d      = FS_HOLD;
            end else begin
              ifid_load = 1'b1;
              pc_d      = pc_plus4;
            end
          end
        end
        FS_HOLD: begin
          if (!stall && hold_valid_q) begin
            ifid_load    = 1'b1;
            ifid_instr   = hold_q;
            pc_d         = pc_plus4;
            hold_valid_d = 1'b0;
            state_d      = FS_FETCH;
          end
        end
        default: state_d = FS_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= FS_IDLE;
      pc_q         <= RESET_PC;
      hold_q       <= '0;
      hold_valid_q <= 1'b0;
      drop_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      hold_q       <= hold_d;
      hold_valid_q <= hold_valid_d;
      drop_q       <= drop_d;
    end
  end

  ifid_reg #(
    .NOP_WORD (NOP_WORD)
  ) u_ifid (
    .clk       (clk),
    .rst       (reset),
    .load_i    (ifid_load),
    .clear_i   (ifid_clear),
    .instr_i   (ifid_instr),
    .pcplus4_i (pc_plus4),
    .instr_o   (instr_d),
    .pcplus4_o (pcplus4_d),
    .valid_o   (valid_d)
  );

  assign op_d    = instr_d[31:26];
  assign funct_d = instr_d[5:0];

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: table-driven zero-wait sequence, directed corner cases,
// then random stall/latency/redirect traffic checked against an instruction-stream model.
module tb_instr_fetch;

  localparam logic [31:0] NOP = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        stall = 1'b0;
  logic        branch_taken = 1'b0;
  logic [31:0] branch_target = '0;
  logic        jump = 1'b0;
  logic        flush = 1'b0;
  logic        imem_ready = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] instr_d;
  logic [31:0] pcplus4_d;
  logic        valid_d;
  logic [5:0]  op_d;
  logic [5:0]  funct_d;

  instr_fetch dut (
    .clk           (clk),
    .reset         (reset),
    .stall         (stall),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .jump          (jump),
    .flush         (flush),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_ready    (imem_ready),
    .imem_rdata    (imem_rdata),
    .instr_d       (instr_d),
    .pcplus4_d     (pcplus4_d),
    .valid_d       (valid_d),
    .op_d          (op_d),
    .funct_d       (funct_d)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Memory model: a few fixed words, everything else derived from the address.
  logic [31:0] mem_ovr [logic [31:0]];
  bit          busy = 1'b0;
  bit          rand_lat = 1'b0;
  logic [31:0] cap_addr = '0;
  int          waited = 0;
  int          lat_cur = 0;
  int          lat_fixed = 0;
  int          n_cap = 0;
  logic        p_req, p_ready;
  logic [31:0] p_addr;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (mem_ovr.exists(a)) return mem_ovr[a];
    return 32'h3C00_0000 | a;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic cycle(input logic st, input logic br, input logic [31:0] tgt,
                       input logic jp, input logic fl);
    @(negedge clk);
    stall = st; branch_taken = br; branch_target = tgt; jump = jp; flush = fl;
    if (imem_req && !busy) begin
      busy = 1'b1; cap_addr = imem_addr; waited = 0; n_cap++;
      lat_cur = rand_lat ? int'($urandom_range(0, 3)) : lat_fixed;
    end
    if (imem_req && busy && waited >= lat_cur) begin
      imem_ready = 1'b1; imem_rdata = mem_word(cap_addr);
    end else begin
      imem_ready = 1'b0; imem_rdata = 32'hDEAD_BEEF;
    end
    p_req = imem_req; p_ready = imem_ready; p_addr = imem_addr;
    @(posedge clk);
    #1;
    if (p_req && p_ready) busy = 1'b0;
    else if (busy) waited++;
  endtask

  task automatic apply_reset();
    reset = 1'b1; stall = 0; branch_taken = 0; jump = 0; flush = 0;
    branch_target = '0; imem_ready = 0; imem_rdata = '0;
    busy = 1'b0; waited = 0; lat_fixed = 0; rand_lat = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_req", imem_req, 0);
    chk("rst_valid", valid_d, 0);
    chk("rst_instr", instr_d, NOP);
    chk("rst_pc", imem_addr, 32'h0);
    reset = 1'b0;
    #1;
    chk("idle_req", imem_req, 0);
  endtask

  typedef struct {
    logic        st, br, jp, fl;
    logic [31:0] tgt;
    logic        exp_req;
    logic [31:0] exp_addr;
    logic        exp_valid;
    logic [31:0] exp_instr;
    logic [31:0] exp_pc4;
  } vec_t;

  function automatic vec_t mk(input logic st, input logic br, input logic jp, input logic fl,
                              input logic [31:0] tgt, input logic req, input logic [31:0] addr,
                              input logic val, input logic [31:0] ins, input logic [31:0] pc4);
    vec_t v;
    v.st = st; v.br = br; v.jp = jp; v.fl = fl; v.tgt = tgt;
    v.exp_req = req; v.exp_addr = addr; v.exp_valid = val; v.exp_instr = ins; v.exp_pc4 = pc4;
    return v;
  endfunction

  vec_t vecs [16];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [31:0] exp_next, p_instr, p_pc4, tgt;
    logic        p_valid, st, br, jp, new_i;
    int          idle, caps;

    mem_ovr[32'h0000_0000] = 32'h0022_1820;  // add
    mem_ovr[32'h0000_0004] = 32'h0800_000A;  // j 0x28
    mem_ovr[32'h0000_0028] = 32'h0022_1822;  // sub

    //            st br jp fl tgt            req addr           v  instr          pc+4
    vecs[0]  = mk(0, 0, 0, 0, 32'h0,         1, 32'h0000_0000, 0, NOP,           32'h0);
    vecs[1]  = mk(0, 0, 0, 0, 32'h0,         1, 32'h0000_0004, 1, 32'h0022_1820, 32'h0000_0004);
    vecs[2]  = mk(0, 0, 0, 0, 32'h0,         1, 32'h0000_0008, 1, 32'h0800_000A, 32'h0000_0008);
    vecs[3]  = mk(0, 0, 1, 1, 32'h0,         1, 32'h0000_0028, 0, NOP,           32'h0);
    vecs[4]  = mk(0, 0, 0, 0, 32'h0,         1, 32'h0000_002C, 1, 32'h0022_1822, 32'h0000_002C);
    vecs[5]  = mk(1, 0, 0, 0, 32'h0,         0, 32'h0000_002C, 1, 32'h0022_1822, 32'h0000_002C);
    vecs[6]  = mk(0, 0, 0, 0, 32'h0,         1, 32'h0000_0030, 1, 32'h3C00_002C, 32'h0000_0030);
    vecs[7]  = mk(0, 1, 0, 0, 32'h100,       1, 32'h0000_0100, 0, NOP,           32'h0);
    vecs[8]  = mk(0, 0, 0, 0, 32'h0,         1, 32'h0000_0104, 1, 32'h3C00_0100, 32'h0000_0104);
    vecs[9]  = mk(0, 1, 1, 0, 32'h200,       1, 32'h0000_0200, 0, NOP,           32'h0);
    vecs[10] = mk(0, 0, 0, 0, 32'h0,         1, 32'h0000_0204, 1, 32'h3C00_0200, 32'h0000_0204);
    vecs[11] = mk(1, 0, 1, 1, 32'h0,         1, 32'h0000_0800, 0, NOP,           32'h0);
    vecs[12] = mk(0, 0, 0, 0, 32'h0,         1, 32'h0000_0804, 1, 32'h3C00_0800, 32'h0000_0804);
    vecs[13] = mk(0, 1, 0, 0, 32'hFFFF_FFFC, 1, 32'hFFFF_FFFC, 0, NOP,           32'h0);
    vecs[14] = mk(0, 0, 0, 0, 32'h0,         1, 32'h0000_0000, 1, 32'hFFFF_FFFC, 32'h0000_0000);
    vecs[15] = mk(0, 0, 0, 0, 32'h0,         1, 32'h0000_0004, 1, 32'h0022_1820, 32'h0000_0004);

    // Zero-wait table: sequential fetch, jump, stall/hold, branch, priorities, pc wrap.
    apply_reset();
    for (int i = 0; i < 16; i++) begin
      cycle(vecs[i].st, vecs[i].br, vecs[i].tgt, vecs[i].jp, vecs[i].fl);
      chk($sformatf("v%0d_req", i), imem_req, vecs[i].exp_req);
      if (vecs[i].exp_req) chk($sformatf("v%0d_addr", i), imem_addr, vecs[i].exp_addr);
      chk($sformatf("v%0d_valid", i), valid_d, vecs[i].exp_valid);
      chk($sformatf("v%0d_instr", i), instr_d, vecs[i].exp_instr);
      chk($sformatf("v%0d_op", i), op_d, vecs[i].exp_instr[31:26]);
      chk($sformatf("v%0d_funct", i), funct_d, vecs[i].exp_instr[5:0]);
      if (vecs[i].exp_valid) chk($sformatf("v%0d_pc4", i), pcplus4_d, vecs[i].exp_pc4);
      $display("vec %0d: req=%0b addr=%h valid=%0b instr=%h pc4=%h",
               i, imem_req, imem_addr, valid_d, instr_d, pcplus4_d);
    end

    // Memory answers 3 cycles late: address held, IF/ID untouched until ready.
    apply_reset();
    cycle(0, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 0);
    lat_fixed = 3;
    for (int i = 0; i < 3; i++) begin
      cycle(0, 0, 0, 0, 0);
      chk($sformatf("wait%0d_req", i), imem_req, 1);
      chk($sformatf("wait%0d_addr", i), imem_addr, 32'h4);
      chk($sformatf("wait%0d_instr", i), instr_d, 32'h0022_1820);
      chk($sformatf("wait%0d_pc4", i), pcplus4_d, 32'h4);
      $display("wait %0d: addr=%h instr=%h", i, imem_addr, instr_d);
    end
    cycle(0, 0, 0, 0, 0);
    chk("wait_done_instr", instr_d, 32'h0800_000A);
    chk("wait_done_pc4", pcplus4_d, 32'h8);

    // Branch while the fetch of 0x10 is outstanding: late word must be discarded.
    apply_reset();
    for (int i = 0; i < 5; i++) cycle(0, 0, 0, 0, 0);
    chk("drop_pre_addr", imem_addr, 32'h10);
    lat_fixed = 2;
    cycle(0, 1, 32'h100, 0, 0);
    lat_fixed = 0;
    chk("drop_br_valid", valid_d, 0);
    chk("drop_br_addr", imem_addr, 32'h100);
    begin
      int k;
      k = 0;
      while (!valid_d && k < 8) begin
        cycle(0, 0, 0, 0, 0);
        k++;
      end
      chk("drop_timeout", valid_d, 1);
      chk("drop_instr", instr_d, mem_word(32'h100));
      chk("drop_pc4", pcplus4_d, 32'h104);
      $display("drop: first word after branch instr=%h pc4=%h", instr_d, pcplus4_d);
    end

    // Stall in the cycle the sub word returns: hold it, then release without refetch.
    apply_reset();
    cycle(0, 0, 0, 0, 0);
    cycle(0, 1, 32'h28, 0, 0);
    chk("hold_pre_addr", imem_addr, 32'h28);
    caps = n_cap;
    cycle(1, 0, 0, 0, 0);
    chk("hold_req", imem_req, 0);
    chk("hold_valid", valid_d, 0);
    cycle(1, 0, 0, 0, 0);
    chk("hold2_req", imem_req, 0);
    chk("hold2_valid", valid_d, 0);
    cycle(0, 0, 0, 0, 0);
    chk("hold_out_instr", instr_d, 32'h0022_1822);
    chk("hold_out_funct", funct_d, 6'h22);
    chk("hold_out_pc4", pcplus4_d, 32'h2C);
    chk("hold_out_valid", valid_d, 1);
    chk("hold_no_refetch", n_cap - caps, 1);
    chk("hold_next_addr", imem_addr, 32'h2C);
    $display("hold: released instr=%h pc4=%h", instr_d, pcplus4_d);

    // Asynchronous reset in the middle of a pending fetch at 0x40.
    apply_reset();
    cycle(0, 0, 0, 0, 0);
    cycle(0, 1, 32'h3C, 0, 0);
    cycle(0, 0, 0, 0, 0);
    lat_fixed = 5;
    cycle(0, 0, 0, 0, 0);
    chk("arst_pre_addr", imem_addr, 32'h40);
    chk("arst_pre_valid", valid_d, 1);
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    chk("arst_req", imem_req, 0);
    chk("arst_pc", imem_addr, 32'h0);
    chk("arst_valid", valid_d, 0);
    chk("arst_instr", instr_d, NOP);
    $display("arst: req=%0b addr=%h valid=%0b", imem_req, imem_addr, valid_d);

    // Random traffic against an instruction-stream model.
    apply_reset();
    rand_lat = 1'b1;
    exp_next = 32'h0;
    idle = 0;
    for (int c = 0; c < 600; c++) begin
      st = ($urandom_range(0, 3) == 0);
      br = ($urandom_range(0, 11) == 0);
      tgt = 32'($urandom_range(0, 1023)) << 2;
      jp = valid_d && ($urandom_range(0, 9) == 0);
      p_valid = valid_d; p_instr = instr_d; p_pc4 = pcplus4_d;
      cycle(st, br, tgt, jp, jp);
      if (br || jp) begin
        exp_next = br ? tgt : {p_pc4[31:28], p_instr[25:0], 2'b00};
        chk("rnd_redirect_valid", valid_d, 0);
        idle = 0;
      end else begin
        new_i = valid_d && (!p_valid || pcplus4_d != p_pc4);
        if (st) begin
          chk("rnd_stall_ifid", {instr_d, pcplus4_d}, {p_instr, p_pc4});
          chk("rnd_stall_valid", valid_d, p_valid);
          idle++;
        end else if (new_i) begin
          chk("rnd_pc4", pcplus4_d, exp_next + 32'd4);
          chk("rnd_instr", instr_d, mem_word(exp_next));
          chk("rnd_op", op_d, mem_word(exp_next) >> 26);
          $display("rnd load addr=%h instr=%h", exp_next, instr_d);
          exp_next = exp_next + 32'd4;
          idle = 0;
        end else begin
          chk("rnd_ifid_stable", {instr_d, pcplus4_d}, {p_instr, p_pc4});
          chk("rnd_valid_stable", valid_d, p_valid);
          idle++;
        end
        if (p_req && !p_ready) chk("rnd_addr_hold", {imem_req, imem_addr}, {1'b1, p_addr});
      end
      if (idle > 60) begin
        chk("rnd_progress", idle, 0);
        break;
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
